// File: rtl/out_mem_stream_reader.sv
// -----------------------------------------------------------------------------
// out_mem_stream_reader
//   Reads the equalized image back out of output memory (128-bit words) once
//   the mapping stage finishes, and serializes each word LSB-byte-first onto an
//   8-bit valid/ready pixel stream. One word is prefetched ahead so an
//   unthrottled consumer sees one pixel per cycle with no bubbles.
//
// Parameters
//   NUM_WORDS  words to read (1..65536)
//   BASE_ADDR  first output-memory word address (address wraps at 16 bits)
//
// Ports
//   clk, reset       clock (rising edge), synchronous active-high reset
//   start            one-cycle pulse, accepted only when idle
//   out_mem_rd_addr  registered read address
//   out_mem_rd_en    registered read strobe; data returns one cycle later
//   out_mem_rd_data  read data, valid the cycle after out_mem_rd_en
//   pix_data/valid/ready/last   pixel stream
//   busy             readout in progress
//   done             one-cycle pulse after the final pixel transfer
// -----------------------------------------------------------------------------
module out_mem_stream_reader #(
   parameter int unsigned NUM_WORDS = 4096,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [15:0]  out_mem_rd_addr,
   output logic         out_mem_rd_en,
   input  logic [127:0] out_mem_rd_data,
   output logic [7:0]   pix_data,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic         pix_last,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

   localparam logic [16:0] NW       = 17'(NUM_WORDS);
   localparam logic [20:0] LAST_PIX = 21'(NUM_WORDS * 16 - 1);

   state_t         state_q, state_d;
   logic [15:0]    addr_q, addr_d;
   logic           rd_en_q, rd_en_d;
   logic           ret_q;                 // read data is on the bus this cycle
   logic [16:0]    issued_q, issued_d;
   logic [127:0]   sr_q, sr_d;
   logic           sr_vld_q, sr_vld_d;
   logic [3:0]     idx_q, idx_d;
   logic [127:0]   pb_q, pb_d;
   logic           pb_vld_q, pb_vld_d;
   logic [20:0]    pix_cnt_q, pix_cnt_d;

   logic           xfer, pop, issue_ok;

   assign xfer = sr_vld_q & pix_ready;
   assign pop  = xfer & (idx_q == 4'hF);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rd_en_d   = 1'b0;
      issued_d  = issued_q;
      sr_d      = sr_q;
      sr_vld_d  = sr_vld_q;
      idx_d     = idx_q;
      pb_d      = pb_q;
      pb_vld_d  = pb_vld_q;
      pix_cnt_d = pix_cnt_q;

      if (xfer) begin
         idx_d     = idx_q + 4'd1;        // wraps to 0 after byte 15
         pix_cnt_d = pix_cnt_q + 21'd1;
      end

      // Byte 15 leaves: reload SR from PB in the same edge, else SR empties.
      if (pop) begin
         if (pb_vld_q) begin
            sr_d     = pb_q;
            pb_vld_d = 1'b0;
         end else begin
            sr_vld_d = 1'b0;
         end
      end

      // Returning word fills SR if it is (becoming) empty, otherwise PB.
      if (ret_q) begin
         if (!sr_vld_d) begin
            sr_d     = out_mem_rd_data;
            sr_vld_d = 1'b1;
         end else begin
            pb_d     = out_mem_rd_data;
            pb_vld_d = 1'b1;
         end
      end

      // With one read outstanding at most, occupancy after this edge is an
      // upper bound on occupancy when a read issued now returns.
      issue_ok = (issued_q < NW) && !rd_en_q && !(sr_vld_d && pb_vld_d);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_STREAM;
               rd_en_d   = 1'b1;
               addr_d    = BASE_ADDR;
               issued_d  = 17'd1;
               pix_cnt_d = '0;
            end
         end
         S_STREAM: begin
            if (issue_ok) begin
               rd_en_d  = 1'b1;
               addr_d   = addr_q + 16'd1;
               issued_d = issued_q + 17'd1;
            end
            // Final word is sitting in SR with nothing behind it.
            if (issued_q == NW && !rd_en_q && !ret_q && !pb_vld_q && sr_vld_q)
               state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (xfer && pix_last)
               state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rd_en_q   <= 1'b0;
         ret_q     <= 1'b0;
         issued_q  <= '0;
         sr_q      <= '0;
         sr_vld_q  <= 1'b0;
         idx_q     <= '0;
         pb_q      <= '0;
         pb_vld_q  <= 1'b0;
         pix_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rd_en_q   <= rd_en_d;
         ret_q     <= rd_en_q;
         issued_q  <= issued_d;
         sr_q      <= sr_d;
         sr_vld_q  <= sr_vld_d;
         idx_q     <= idx_d;
         pb_q      <= pb_d;
         pb_vld_q  <= pb_vld_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   assign out_mem_rd_addr = addr_q;
   assign out_mem_rd_en   = rd_en_q;
   assign pix_valid       = sr_vld_q;
   assign pix_data        = sr_q[{idx_q, 3'b000} +: 8];
   assign pix_last        = sr_vld_q && (pix_cnt_q == LAST_PIX);
   assign busy            = (state_q == S_STREAM) || (state_q == S_FLUSH);
   assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_out_mem_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_out_mem_stream_reader
//   Three reader instances (2 words @0, 4 words @0, 1 word @FFFF) share clock,
//   reset and pix_ready. The expected pixel stream is built from the memory
//   contents as a flat list of bytes; a per-cycle monitor compares transfers,
//   read addresses, stall stability and done timing against it.
// -----------------------------------------------------------------------------
module tb_out_mem_stream_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         ready;
   logic         start  [3];
   logic [15:0]  addr   [3];
   logic         en     [3];
   logic [127:0] rdata  [3];
   logic [7:0]   pdata  [3];
   logic         pvalid [3];
   logic         plast  [3];
   logic         busy   [3];
   logic         done_o [3];

   out_mem_stream_reader #(.NUM_WORDS(2), .BASE_ADDR(16'h0000)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .out_mem_rd_addr(addr[0]),
      .out_mem_rd_en(en[0]), .out_mem_rd_data(rdata[0]), .pix_data(pdata[0]),
      .pix_valid(pvalid[0]), .pix_ready(ready), .pix_last(plast[0]),
      .busy(busy[0]), .done(done_o[0]));

   out_mem_stream_reader #(.NUM_WORDS(4), .BASE_ADDR(16'h0000)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .out_mem_rd_addr(addr[1]),
      .out_mem_rd_en(en[1]), .out_mem_rd_data(rdata[1]), .pix_data(pdata[1]),
      .pix_valid(pvalid[1]), .pix_ready(ready), .pix_last(plast[1]),
      .busy(busy[1]), .done(done_o[1]));

   out_mem_stream_reader #(.NUM_WORDS(1), .BASE_ADDR(16'hFFFF)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .out_mem_rd_addr(addr[2]),
      .out_mem_rd_en(en[2]), .out_mem_rd_data(rdata[2]), .pix_data(pdata[2]),
      .pix_valid(pvalid[2]), .pix_ready(ready), .pix_last(plast[2]),
      .busy(busy[2]), .done(done_o[2]));

   int pat_mode;
   int seed;

   function automatic logic [15:0] base_of(int i);
      return (i == 2) ? 16'hFFFF : 16'h0000;
   endfunction

   function automatic int nw_of(int i);
      case (i)
         0: return 2;
         1: return 4;
         default: return 1;
      endcase
   endfunction

   // Memory content: pattern 0 gives byte value = running pixel number.
   function automatic logic [7:0] mem_byte(int i, logic [15:0] a, int n);
      logic [15:0] w;
      w = a - base_of(i);
      if (pat_mode == 0) return 8'(int'(w) * 16 + n);
      return 8'((int'(w) * 37 + n * 11 + seed) ^ (seed >> n));
   endfunction

   function automatic logic [127:0] mem_word(int i, logic [15:0] a);
      logic [127:0] wd;
      for (int n = 0; n < 16; n++) wd[8*n +: 8] = mem_byte(i, a, n);
      return wd;
   endfunction

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk)
      for (int i = 0; i < 3; i++)
         if (en[i]) rdata[i] <= mem_word(i, addr[i]);

   int checks = 0;
   int fails  = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   int         sel, cyc, n_reads, n_xfer, n_done, vcnt, first_v, last_v;
   int         accept_cyc, last_xfer_cyc, stall_reads;
   bit         mon_en;
   logic       prev_v, prev_r, prev_en, prev_busy, prev_l;
   logic [7:0] prev_d;
   logic [8:0] exp_q [$];           // {last, byte}

   task automatic monitor();
      logic v, r, l;
      logic [7:0] d;
      logic [8:0] e;
      v = pvalid[sel]; r = ready; l = plast[sel]; d = pdata[sel];
      if (!mon_en) return;
      if (en[sel]) begin
         chk("rd_addr", 32'(addr[sel]), 32'(16'(base_of(sel) + 16'(n_reads))));
         chk("rd_outstanding", 32'(prev_en), 0);
         n_reads++;
         chk("rd_buffered", 32'(n_reads - n_xfer / 16 <= 2), 1);
         chk("rd_count", 32'(n_reads <= nw_of(sel)), 1);
      end
      if (v && prev_v && !prev_r) begin
         chk("stall_data", 32'(d), 32'(prev_d));
         chk("stall_last", 32'(l), 32'(prev_l));
      end
      if (v) begin
         if (vcnt == 0) first_v = cyc;
         last_v = cyc;
         vcnt++;
      end
      if (v && r) begin
         chk("pixels_left", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix_data", 32'(d), 32'(e[7:0]));
            chk("pix_last", 32'(l), 32'(e[8]));
         end
         n_xfer++;
         last_xfer_cyc = cyc;
      end
      if (done_o[sel]) begin
         n_done++;
         chk("done_timing", cyc, last_xfer_cyc + 1);
         chk("done_busy_low", 32'(busy[sel]), 0);
      end
      if (busy[sel] && !prev_busy) accept_cyc = cyc;
      prev_v = v; prev_r = r; prev_l = l; prev_d = d;
      prev_en = en[sel]; prev_busy = busy[sel];
   endtask

   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_run(int inst);
      logic [15:0] a;
      sel = inst; mon_en = 1'b1;
      n_reads = 0; n_xfer = 0; n_done = 0; vcnt = 0; first_v = -1; last_v = -1;
      accept_cyc = -100; last_xfer_cyc = -100; stall_reads = -1;
      prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 0; prev_en = 0;
      prev_busy = busy[inst];
      exp_q.delete();
      for (int w = 0; w < nw_of(inst); w++) begin
         a = 16'(base_of(inst) + 16'(w));
         for (int n = 0; n < 16; n++)
            exp_q.push_back({(w == nw_of(inst) - 1 && n == 15), mem_byte(inst, a, n)});
      end
   endtask

   task automatic run(input int inst, input bit rnd, input int stall,
                      input int restart_at, input int abort_at, output bit aborted);
      begin_run(inst);
      aborted = 1'b0;
      ready = (stall > 0) ? 1'b0 : 1'b1;
      start[inst] = 1'b1;
      cycle();
      start[inst] = 1'b0;
      for (int k = 0; k < 4000 && n_done == 0; k++) begin
         if (abort_at > 0 && n_xfer >= abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (stall > 0 && k == stall) stall_reads = n_reads;
         ready = (k < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         start[inst] = (k == restart_at);
         cycle();
      end
      start[inst] = 1'b0;
      if (!aborted) begin
         ready = 1'b1;
         repeat (4) cycle();
         chk("single_done", n_done, 1);
         chk("all_pixels", n_xfer, 16 * nw_of(inst));
         chk("exp_drained", exp_q.size(), 0);
         chk("read_total", n_reads, nw_of(inst));
         chk("first_valid", first_v, accept_cyc + 2);
      end
   endtask

   initial begin
      bit ab;
      reset = 1'b1; ready = 1'b0; pat_mode = 0; seed = 0;
      mon_en = 1'b0; sel = 0; cyc = 0;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_addr",  32'(addr[i]),   0);
         chk("rst_rd_en", 32'(en[i]),     0);
         chk("rst_data",  32'(pdata[i]),  0);
         chk("rst_valid", 32'(pvalid[i]), 0);
         chk("rst_last",  32'(plast[i]),  0);
         chk("rst_busy",  32'(busy[i]),   0);
         chk("rst_done",  32'(done_o[i]), 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) cycle();

      // Two words, full-rate consumer: 32 contiguous pixels 0x00..0x1F.
      run(0, 1'b0, 0, -1, 0, ab);
      chk("valid_cycles", vcnt, 32);
      chk("contiguous", last_v - first_v, 31);

      // Same image, random backpressure.
      run(0, 1'b1, 0, -1, 0, ab);

      // Four words, consumer stalled 40 cycles after start.
      pat_mode = 1; seed = int'($urandom);
      run(1, 1'b1, 40, -1, 0, ab);
      chk("stall_reads", stall_reads, 2);

      // Second start mid-stream is ignored.
      seed = int'($urandom);
      run(1, 1'b1, 0, 20, 0, ab);

      // Reset after 10 pixels, then a clean restart from the base address.
      pat_mode = 0;
      run(0, 1'b1, 0, -1, 10, ab);
      chk("abort_reached", 32'(ab), 1);
      mon_en = 1'b0;
      reset = 1'b1;
      cycle();
      @(negedge clk);
      chk("abort_addr",  32'(addr[0]),   0);
      chk("abort_rd_en", 32'(en[0]),     0);
      chk("abort_data",  32'(pdata[0]),  0);
      chk("abort_valid", 32'(pvalid[0]), 0);
      chk("abort_last",  32'(plast[0]),  0);
      chk("abort_busy",  32'(busy[0]),   0);
      chk("abort_done",  32'(done_o[0]), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("post_abort_valid", 32'(pvalid[0]), 0);
         chk("post_abort_done",  32'(done_o[0]), 0);
      end
      run(0, 1'b1, 0, -1, 0, ab);

      // Single word at the top of the address space.
      pat_mode = 1; seed = int'($urandom);
      run(2, 1'b0, 0, -1, 0, ab);
      chk("wrap_valid_cycles", vcnt, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
